nonce_sequencer: RTL and testbench

// - Upstream driver of the 128-bit block concatenator. Latches the 96-bit header
//   (entrada) and sweeps a 32-bit nonce, issuing one entrada/nonce pair at a time.
// - Waits for the micro-hash result of each pair and compares its top bits to a target.
// - Stops on the first hit, reporting that nonce, or stops on nonce-range exhaustion.

---
 rtl/nonce_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nonce_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/nonce_sequencer.sv
// Nonce sweeper feeding the 128-bit block concatenator: latches a 96-bit header,
// issues one header/nonce pair at a time, and stops on the first hash below target.
// Optional build macro: NONCE_SEQ_TIMEOUT_EN adds a watchdog on the WAIT state.
module nonce_sequencer #(
  parameter int unsigned        DATA_W    = 96,
  parameter int unsigned        NONCE_W   = 32,
  parameter int unsigned        HASH_W    = 24,
  parameter int unsigned        TGT_W     = 8,
  parameter logic [NONCE_W-1:0] NONCE_MAX = {NONCE_W{1'b1}},
  parameter int unsigned        TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  entrada_in,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [TGT_W-1:0]   target,
  output logic [DATA_W-1:0]  entrada,
  output logic [NONCE_W-1:0] nonce,
  output logic               blk_valid,
  input  logic               blk_ready,
  input  logic               hash_valid,
  input  logic [HASH_W-1:0]  hash_in,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] nonce_found,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  entrada_q, entrada_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [TGT_W-1:0]   target_q, target_d;
  logic               found_q, found_d;
  logic [NONCE_W-1:0] nonce_found_q, nonce_found_d;

  // Only the top TGT_W bits of the hash take part in the compare.
  logic [TGT_W-1:0] hash_field;
  logic             hit;
  logic             unused_hash_lsbs;

  assign hash_field       = hash_in[HASH_W-1 -: TGT_W];
  assign hit              = (hash_field < target_q);
  assign unused_hash_lsbs = ^hash_in[HASH_W-TGT_W-1:0];

`ifdef NONCE_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
`endif

  // Next-state and datapath update for the IDLE/ISSUE/WAIT/DONE sweep.
  always_comb begin
    state_d       = state_q;
    entrada_d     = entrada_q;
    nonce_d       = nonce_q;
    target_d      = target_q;
    found_d       = found_q;
    nonce_found_d = nonce_found_q;
`ifdef NONCE_SEQ_TIMEOUT_EN
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          entrada_d = entrada_in;
          nonce_d   = nonce_base;
          target_d  = target;
          found_d   = 1'b0;
`ifdef NONCE_SEQ_TIMEOUT_EN
          tmo_d     = 1'b0;
`endif
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Header and nonce stay put until the hash core takes the pair.
        if (blk_ready) begin
          state_d = WAIT;
`ifdef NONCE_SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (hash_valid) begin
          if (hit) begin
            found_d       = 1'b1;
            nonce_found_d = nonce_q;
            state_d       = DONE;
          end else if (nonce_q >= NONCE_MAX) begin
            // Leave nonce on the last value tried so exhaustion is visible.
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            nonce_d = nonce_q + 1'b1;
            state_d = ISSUE;
          end
        end
`ifdef NONCE_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          found_d = 1'b0;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any search in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      entrada_q     <= '0;
      nonce_q       <= '0;
      target_q      <= '0;
      found_q       <= 1'b0;
      nonce_found_q <= '0;
    end else begin
      state_q       <= state_d;
      entrada_q     <= entrada_d;
      nonce_q       <= nonce_d;
      target_q      <= target_d;
      found_q       <= found_d;
      nonce_found_q <= nonce_found_d;
    end
  end

`ifdef NONCE_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Status outputs decode straight from the registered state.
  assign entrada     = entrada_q;
  assign nonce       = nonce_q;
  assign nonce_found = nonce_found_q;
  assign found       = found_q;
  assign blk_valid   = (state_q == ISSUE);
  assign busy        = (state_q == ISSUE) || (state_q == WAIT);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_nonce_sequencer.sv
// Randomized bench for nonce_sequencer: a behavioural hash core answers each
// transferred pair after a random delay, and a search-level model predicts the
// outcome (first hit or exhaustion) from base, target and the hash function.
module tb_nonce_sequencer;
  localparam int unsigned DW = 96;
  localparam int unsigned NW = 32;
  localparam int unsigned HW = 24;
  localparam int unsigned TW = 8;
  localparam logic [NW-1:0] NMAX = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] entrada_in = '0;
  logic [NW-1:0] nonce_base = '0;
  logic [TW-1:0] target = '0;
  logic [DW-1:0] entrada;
  logic [NW-1:0] nonce;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          hash_valid = 1'b0;
  logic [HW-1:0] hash_in = '0;
  logic          busy, done, found, timeout_err;
  logic [NW-1:0] nonce_found;

  int errs = 0;
  int checks = 0;
  int hmode = 0;
  logic [31:0] hseed = 32'h1234_5678;

  nonce_sequencer #(
    .DATA_W(DW), .NONCE_W(NW), .HASH_W(HW), .TGT_W(TW), .NONCE_MAX(NMAX), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .entrada_in(entrada_in),
    .nonce_base(nonce_base), .target(target), .entrada(entrada), .nonce(nonce),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .hash_valid(hash_valid),
    .hash_in(hash_in), .busy(busy), .done(done), .found(found),
    .nonce_found(nonce_found), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hash core behaviour: top byte of the hash for a given nonce.
  function automatic logic [7:0] hfield(input logic [31:0] n);
    logic [31:0] m;
    if (hmode == 1) return (n == 32'h13) ? 8'h02 : 8'hFF;
    m = (n * 32'd2654435761) ^ hseed;
    m = m ^ (m >> 15);
    return m[7:0];
  endfunction

  // Search-level reference: walk nonces from base, stop on hit or at NMAX.
  task automatic model(input logic [31:0] base, input logic [7:0] tgt,
                       output logic efound, output logic [31:0] elast, output int ecnt);
    logic [31:0] n;
    n = base;
    ecnt = 0;
    efound = 1'b0;
    elast = base;
    while (ecnt < 1000) begin
      ecnt++;
      elast = n;
      if (hfield(n) < tgt) begin
        efound = 1'b1;
        break;
      end
      if (n >= NMAX) break;
      n = n + 1;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_entrada"}, entrada, '0);
    check_eq({pfx, "_nonce"}, nonce, '0);
    check_eq({pfx, "_nonce_found"}, nonce_found, '0);
    check_eq({pfx, "_ctrl"}, {blk_valid, busy, done, found, timeout_err}, 5'b0);
  endtask

  task automatic run_search(input logic [31:0] base, input logic [7:0] tgt,
                            input int rdy_pct, input int stall_first);
    logic        efound;
    logic [31:0] elast, exp_n, prev_nonce, held_nf;
    logic [95:0] ent, prev_ent;
    logic        prev_vld, held_found;
    int          ecnt, ntx, seq_bad, hold_bad, pending, stall, cyc;
    model(base, tgt, efound, elast, ecnt);
    ent = {$urandom, $urandom, $urandom};
    exp_n = base; ntx = 0; seq_bad = 0; hold_bad = 0; pending = -1;
    stall = stall_first; prev_vld = 1'b0; prev_nonce = '0; prev_ent = '0;
    @(negedge clk);
    entrada_in = ent; nonce_base = base; target = tgt; start = 1'b1;
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      start = 1'b0; blk_ready = 1'b0; hash_valid = 1'b0;
      entrada_in = {$urandom, $urandom, $urandom}; nonce_base = $urandom; target = 8'hFF;
      if (done) break;
      if (blk_valid) begin
        if (prev_vld && (nonce !== prev_nonce || entrada !== prev_ent)) hold_bad++;
        prev_vld = 1'b1; prev_nonce = nonce; prev_ent = entrada;
        if (stall > 0) stall--;
        else blk_ready = ($urandom_range(0, 99) < rdy_pct);
        if (blk_ready) begin
          if (nonce !== exp_n) seq_bad++;
          exp_n = exp_n + 1; ntx++; prev_vld = 1'b0;
          pending = $urandom_range(0, 3);
        end else if ($urandom_range(0, 2) == 0) begin
          hash_valid = 1'b1;
          hash_in = {8'h00, 16'($urandom)};
        end
      end else if (pending == 0) begin
        hash_valid = 1'b1;
        hash_in = {hfield(exp_n - 1), 16'($urandom)};
        pending = -1;
      end else if (pending > 0) begin
        pending--;
      end
      if (busy && $urandom_range(0, 5) == 0) start = 1'b1;
    end
    check_eq("search_done", done, 1'b1);
    check_eq("search_found", found, efound);
    if (efound) check_eq("search_nonce_found", nonce_found, elast);
    check_eq("search_last_nonce", nonce, elast);
    check_eq("search_transfers", ntx, ecnt);
    check_eq("search_entrada", entrada, ent);
    check_eq("search_sequence_errs", seq_bad, 0);
    check_eq("search_stall_hold_errs", hold_bad, 0);
    check_eq("search_idle_flags", {busy, blk_valid, timeout_err}, 3'b0);
    held_found = found; held_nf = nonce_found;
    for (int i = 0; i < 3; i++) begin
      hash_valid = 1'b1;
      hash_in = {8'h00, 16'($urandom)};
      @(negedge clk);
    end
    hash_valid = 1'b0;
    check_eq("done_hold", {done, found, nonce_found, nonce, entrada},
             {1'b1, held_found, held_nf, elast, ent});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("idle");

    // Directed: hit at 0x13 after a 10-cycle ready stall on the first pair.
    hmode = 1;
    run_search(32'h10, 8'h05, 100, 10);
    // Exhaustion at NMAX with a never-hitting target.
    run_search(32'hFC, 8'h00, 100, 0);
    // Base above NMAX: one attempt only.
    run_search(32'h1000, 8'h05, 70, 0);
    // Immediate hit on the first nonce.
    run_search(32'h13, 8'h03, 60, 2);

    // Randomized sweeps against the model.
    hmode = 0;
    for (int k = 0; k < 12; k++) begin
      hseed = $urandom;
      run_search($urandom_range(0, 300), 8'($urandom_range(0, 40)),
                 $urandom_range(50, 100), $urandom_range(0, 3));
    end

    // Reset in the middle of WAIT aborts, and a later hash is ignored.
    hmode = 1;
    @(negedge clk);
    entrada_in = {3{32'hA5A5_5A5A}}; nonce_base = 32'h13; target = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0; blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check_eq("pre_reset_wait", {busy, blk_valid}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid_wait_reset");
    hash_valid = 1'b1; hash_in = 24'h00_0000;
    @(negedge clk);
    hash_valid = 1'b0;
    @(negedge clk);
    check_reset_state("post_reset_hash");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
